// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the FP compare/min-max/classify path:
//   - fp_op_e      : 3-bit op encodings (FEQ, FLT, FLE, FMIN, FMAX, FCLASS, 2 reserved)
//   - FP_CANON_NAN : canonical quiet NaN returned by FMIN/FMAX when both inputs are NaN
//   - FCLASS_*     : bit positions of the 10-bit RISC-V FCLASS mask
//   - fp_class_t   : per-operand class bits produced by fp_class
//   - fclass_mask  : turns an fp_class_t into the FCLASS mask
// -----------------------------------------------------------------------------
package fp_pkg;

    typedef enum logic [2:0] {
        FP_OP_FEQ    = 3'b000,
        FP_OP_FLT    = 3'b001,
        FP_OP_FLE    = 3'b010,
        FP_OP_FMIN   = 3'b011,
        FP_OP_FMAX   = 3'b100,
        FP_OP_FCLASS = 3'b101,
        FP_OP_RSV6   = 3'b110,
        FP_OP_RSV7   = 3'b111
    } fp_op_e;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

    localparam int FCLASS_NEG_INF  = 0;
    localparam int FCLASS_NEG_NORM = 1;
    localparam int FCLASS_NEG_SUB  = 2;
    localparam int FCLASS_NEG_ZERO = 3;
    localparam int FCLASS_POS_ZERO = 4;
    localparam int FCLASS_POS_SUB  = 5;
    localparam int FCLASS_POS_NORM = 6;
    localparam int FCLASS_POS_INF  = 7;
    localparam int FCLASS_SNAN     = 8;
    localparam int FCLASS_QNAN     = 9;

    typedef struct packed {
        logic sign;
        logic snan;
        logic qnan;
        logic inf;
        logic zero;
        logic subnormal;
        logic normal;
    } fp_class_t;

    // Exactly one of the ten mask bits is set for any operand.
    function automatic logic [9:0] fclass_mask(input fp_class_t c);
        logic [9:0] m;
        m                  = '0;
        m[FCLASS_NEG_INF]  =  c.sign & c.inf;
        m[FCLASS_NEG_NORM] =  c.sign & c.normal;
        m[FCLASS_NEG_SUB]  =  c.sign & c.subnormal;
        m[FCLASS_NEG_ZERO] =  c.sign & c.zero;
        m[FCLASS_POS_ZERO] = ~c.sign & c.zero;
        m[FCLASS_POS_SUB]  = ~c.sign & c.subnormal;
        m[FCLASS_POS_NORM] = ~c.sign & c.normal;
        m[FCLASS_POS_INF]  = ~c.sign & c.inf;
        m[FCLASS_SNAN]     =  c.snan;
        m[FCLASS_QNAN]     =  c.qnan;
        return m;
    endfunction

endpackage

// File: rtl/fp_cmp_unit_if.sv
// -----------------------------------------------------------------------------
// fp_cmp_unit_if
// Operand/result handshake bundle of fp_cmp_unit.
//   in_valid/in_ready   : operand bundle handshake (op, rs1, rs2)
//   out_valid/out_ready : result handshake (result, fflag_nv)
// Modports:
//   master : issuing side (drives operands, consumes results)
//   slave  : the compare unit
// -----------------------------------------------------------------------------
interface fp_cmp_unit_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        fflag_nv;

    modport master (
        output in_valid, op, rs1, rs2, out_ready,
        input  in_ready, out_valid, result, fflag_nv
    );

    modport slave (
        input  in_valid, op, rs1, rs2, out_ready,
        output in_ready, out_valid, result, fflag_nv
    );

endinterface

// File: rtl/fp_cmp_unit_class.sv
// -----------------------------------------------------------------------------
// fp_class
// Combinational IEEE-754 single-precision operand classifier.
// Ports:
//   value : 32-bit operand
//   cls   : sign, sNaN, qNaN, infinity, zero, subnormal, normal (one-hot
//           apart from sign)
// -----------------------------------------------------------------------------
module fp_class
    import fp_pkg::*;
(
    input  logic [31:0] value,
    output fp_class_t   cls
);

    logic [7:0]  exponent;
    logic [22:0] mantissa;
    logic        exp_max;
    logic        exp_min;
    logic        man_zero;

    assign exponent = value[30:23];
    assign mantissa = value[22:0];
    assign exp_max  = (exponent == 8'hFF);
    assign exp_min  = (exponent == 8'h00);
    assign man_zero = (mantissa == 23'd0);

    // NOTE: every field of a combinational output gets a value on every path;
    // filling the struct from one expression per field keeps this latch-free.
    always_comb begin
        cls.sign      = value[31];
        cls.inf       = exp_max &  man_zero;
        // The quiet bit is the MSB of the mantissa; a NaN without it is signaling.
        cls.qnan      = exp_max & ~man_zero &  mantissa[22];
        cls.snan      = exp_max & ~man_zero & ~mantissa[22];
        cls.zero      = exp_min &  man_zero;
        cls.subnormal = exp_min & ~man_zero;
        cls.normal    = ~exp_max & ~exp_min;
    end

endmodule

// File: rtl/fp_cmp_unit.sv
// -----------------------------------------------------------------------------
// fp_cmp_unit
// Two-stage RV32F compare / min-max / classify unit.
//   S1 registers op, both operands and their class bits.
//   S2 registers result and the invalid-operation flag.
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset, discards in-flight bundles
//   bus : fp_cmp_unit_if.slave
//         in_valid/in_ready, op[2:0], rs1, rs2      -> operand bundle
//         out_valid/out_ready, result[31:0], fflag_nv -> result
// Configuration macro:
//   FP_CMP_FCLASS_EN : when defined op 101 returns the FCLASS mask of rs1;
//                      otherwise op 101 behaves as a reserved op (result 0).
// Latency 2 cycles, throughput 1/cycle; in_ready depends combinationally on
// out_ready so a full pipe can accept and drain in the same cycle.
// -----------------------------------------------------------------------------
module fp_cmp_unit
    import fp_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fp_cmp_unit_if.slave  bus
);

    // ---------------------------------------------------------------- handshake
    logic s1_valid;
    logic s2_valid;
    logic s1_ready;
    logic s2_ready;

    assign s2_ready     = ~s2_valid | bus.out_ready;
    assign s1_ready     = ~s1_valid | s2_ready;
    assign bus.in_ready = s1_ready;

    // ------------------------------------------------------------- classifiers
    fp_class_t cls_a;
    fp_class_t cls_b;

    fp_class u_class_a (.value(bus.rs1), .cls(cls_a));
    fp_class u_class_b (.value(bus.rs2), .cls(cls_b));

    // ---------------------------------------------------------------- stage 1
    fp_op_e      s1_op;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    fp_class_t   s1_ca;
    fp_class_t   s1_cb;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= bus.in_valid;
        end
    end

    // NOTE: the payload registers carry no reset; they are only observed while
    // s1_valid is set, so clearing them would cost reset routing for nothing.
    always_ff @(posedge clk) begin
        if (bus.in_valid && s1_ready) begin
            s1_op <= fp_op_e'(bus.op);
            s1_a  <= bus.rs1;
            s1_b  <= bus.rs2;
            s1_ca <= cls_a;
            s1_cb <= cls_b;
        end
    end

    // ------------------------------------------------------ stage 2 datapath
    logic        nan_a;
    logic        nan_b;
    logic        any_nan;
    logic        any_snan;
    logic        both_zero;
    logic        mag_lt;
    logic        mag_gt;
    logic        lt_raw;
    logic        lt;
    logic        eq;
    logic [31:0] res_d;
    logic        nv_d;

    assign nan_a     = s1_ca.snan | s1_ca.qnan;
    assign nan_b     = s1_cb.snan | s1_cb.qnan;
    assign any_nan   = nan_a | nan_b;
    assign any_snan  = s1_ca.snan | s1_cb.snan;
    assign both_zero = s1_ca.zero & s1_cb.zero;
    assign mag_lt    = (s1_a[30:0] < s1_b[30:0]);
    assign mag_gt    = (s1_a[30:0] > s1_b[30:0]);

    // Sign-magnitude ordering where -0 < +0; used directly by FMIN/FMAX.
    assign lt_raw = ( s1_ca.sign & ~s1_cb.sign)
                  | (~s1_ca.sign & ~s1_cb.sign & mag_lt)
                  | ( s1_ca.sign &  s1_cb.sign & mag_gt);

    // Compare ordering: +0 and -0 are equal, so neither is less than the other.
    assign lt = lt_raw & ~both_zero;
    assign eq = (s1_a == s1_b) | both_zero;

    always_comb begin
        res_d = '0;
        nv_d  = 1'b0;
        unique case (s1_op)
            FP_OP_FEQ: begin
                res_d[0] = ~any_nan & eq;
                nv_d     = any_snan;
            end
            FP_OP_FLT: begin
                res_d[0] = ~any_nan & lt;
                nv_d     = any_nan;
            end
            FP_OP_FLE: begin
                res_d[0] = ~any_nan & (lt | eq);
                nv_d     = any_nan;
            end
            FP_OP_FMIN: begin
                if (nan_a && nan_b) res_d = FP_CANON_NAN;
                else if (nan_a)     res_d = s1_b;
                else if (nan_b)     res_d = s1_a;
                else                res_d = lt_raw ? s1_a : s1_b;
                nv_d = any_snan;
            end
            FP_OP_FMAX: begin
                if (nan_a && nan_b) res_d = FP_CANON_NAN;
                else if (nan_a)     res_d = s1_b;
                else if (nan_b)     res_d = s1_a;
                else                res_d = lt_raw ? s1_b : s1_a;
                nv_d = any_snan;
            end
`ifdef FP_CMP_FCLASS_EN
            FP_OP_FCLASS: begin
                res_d[9:0] = fclass_mask(s1_ca);
            end
`endif
            default: begin
                // Reserved ops (and FCLASS when disabled) return 0 without NV.
                res_d = '0;
                nv_d  = 1'b0;
            end
        endcase
    end

    // Class bits that only the FCLASS mask would read.
`ifdef FP_CMP_FCLASS_EN
    logic unused_class;
    assign unused_class = ^{s1_cb.inf, s1_cb.subnormal, s1_cb.normal};
`else
    logic unused_class;
    assign unused_class = ^{s1_cb.inf, s1_cb.subnormal, s1_cb.normal,
                            s1_ca.inf, s1_ca.subnormal, s1_ca.normal};
`endif

    // ---------------------------------------------------------------- stage 2
    logic [31:0] s2_result;
    logic        s2_nv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_nv     <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            // Hold the last result when nothing new arrives.
            if (s1_valid) begin
                s2_result <= res_d;
                s2_nv     <= nv_d;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;
    assign bus.fflag_nv  = s2_nv;

endmodule

// File: tb/tb_fp_cmp_unit.sv
// -----------------------------------------------------------------------------
// tb_fp_cmp_unit
// Directed vectors for fp_cmp_unit. The driver pushes each accepted bundle's
// hand-computed response onto a scoreboard queue; an independent monitor pops
// and compares whenever a result transfers. FCLASS expectations follow
// FP_CMP_FCLASS_EN.
// -----------------------------------------------------------------------------
module tb_fp_cmp_unit;
    import fp_pkg::*;

    typedef struct {
        logic [31:0] r;
        logic        nv;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    exp_t sb[$];

    fp_cmp_unit_if bus ();

    fp_cmp_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one bundle until it is accepted; record the expected response.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic env, input string name);
        exp_t e;
        bit   done;
        done = 0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op       = op;
            bus.rs1      = a;
            bus.rs2      = b;
            #1;
            if (bus.in_ready) begin
                e.r = er; e.nv = env; e.name = name;
                sb.push_back(e);
                done = 1;
            end
        end
        if (!done) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 30 && sb.size() != 0; t++) @(negedge clk);
        bus.in_valid = 1'b0;
        check(name, sb.size(), 32'd0);
    endtask

    // ----------------------------------------------------------------- monitor
    bit          held;
    logic [31:0] held_r;

    initial begin
        exp_t e;
        held = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid) begin
                if (held) check("hold_stable", bus.result, held_r);
                if (bus.out_ready) begin
                    held = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_result"}, bus.result, e.r);
                        check({e.name, "_nv"}, {31'd0, bus.fflag_nv}, {31'd0, e.nv});
                    end
                end else begin
                    held   = 1;
                    held_r = bus.result;
                end
            end else begin
                held = 0;
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    logic [31:0] st_a [4];
    logic [31:0] st_b [4];
    logic [31:0] st_e [4];
    logic [31:0] cls_exp [4];

    initial begin
        int   acc_cyc;
        bit   got;
        int   i;
        int   stall;
        bit   seen;
        bit   drop_seen;
        exp_t e;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 3'd0;
        bus.rs1      = '0;
        bus.rs2      = '0;
        bus.out_ready = 1'b1;

`ifdef FP_CMP_FCLASS_EN
        cls_exp[0] = 32'h0000_0020;
        cls_exp[1] = 32'h0000_0001;
        cls_exp[2] = 32'h0000_0100;
        cls_exp[3] = 32'h0000_0200;
`else
        cls_exp[0] = 32'h0;
        cls_exp[1] = 32'h0;
        cls_exp[2] = 32'h0;
        cls_exp[3] = 32'h0;
`endif

        // Reset state.
        #1;
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("reset_result",    bus.result,             32'd0);
        check("reset_nv",        {31'd0, bus.fflag_nv},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Latency: accepted at sample cycle c -> out_valid seen at cycle c+2.
        send(FP_OP_FEQ, 32'h8000_0000, 32'h0000_0000, 32'd1, 1'b0, "feq_pm_zero");
        acc_cyc = cyc;
        got = 0;
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid) got = 1;
        end
        check("latency", cyc, acc_cyc + 2);
        drain("drain_latency");

        // Back-to-back directed vectors, out_ready held high.
        send(FP_OP_FLT,  32'h7FC0_0000, 32'h3F80_0000, 32'd0,         1'b1, "flt_qnan");
        send(FP_OP_FEQ,  32'h7FC0_0000, 32'h3F80_0000, 32'd0,         1'b0, "feq_qnan");
        send(FP_OP_FMIN, 32'h7F80_0001, 32'hC000_0000, 32'hC000_0000, 1'b1, "fmin_snan");
        send(FP_OP_FMAX, 32'h7FC0_0001, 32'hFFC0_0000, 32'h7FC0_0000, 1'b0, "fmax_2qnan");
        send(FP_OP_FMIN, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, "fmin_zeros");
        send(FP_OP_FMAX, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, "fmax_zeros");
        send(FP_OP_FCLASS, 32'h0000_0001, 32'h3F80_0000, cls_exp[0],  1'b0, "fclass_psub");
        send(FP_OP_FCLASS, 32'hFF80_0000, 32'h0000_0000, cls_exp[1],  1'b0, "fclass_ninf");
        send(FP_OP_FCLASS, 32'h7F80_0001, 32'h0000_0000, cls_exp[2],  1'b0, "fclass_snan");
        send(FP_OP_FCLASS, 32'h7FC0_0000, 32'h0000_0000, cls_exp[3],  1'b0, "fclass_qnan");
        send(FP_OP_FLE,  32'h3F80_0000, 32'h3F80_0000, 32'd1,         1'b0, "fle_equal");
        send(FP_OP_FLE,  32'h4000_0000, 32'h3F80_0000, 32'd0,         1'b0, "fle_greater");
        send(FP_OP_FLE,  32'h8000_0000, 32'h0000_0000, 32'd1,         1'b0, "fle_zeros");
        send(FP_OP_FLT,  32'hC000_0000, 32'hBF80_0000, 32'd1,         1'b0, "flt_negs");
        send(FP_OP_FLT,  32'h0000_0000, 32'h8000_0000, 32'd0,         1'b0, "flt_zeros");
        send(FP_OP_FEQ,  32'h7F80_0001, 32'h3F80_0000, 32'd0,         1'b1, "feq_snan");
        send(3'b110,     32'h3F80_0000, 32'h3F80_0000, 32'd0,         1'b0, "reserved6");
        send(3'b111,     32'h7F80_0001, 32'h7F80_0001, 32'd0,         1'b0, "reserved7");
        send(FP_OP_FMIN, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0, "fmin_pos");
        send(FP_OP_FMAX, 32'hBF80_0000, 32'hC000_0000, 32'hBF80_0000, 1'b0, "fmax_neg");
        idle();
        drain("drain_directed");

        // Stream of 4 FLT with a 3-cycle stall on the first result.
        st_a[0] = 32'h3F80_0000; st_b[0] = 32'h4000_0000; st_e[0] = 32'd1;
        st_a[1] = 32'h4000_0000; st_b[1] = 32'h3F80_0000; st_e[1] = 32'd0;
        st_a[2] = 32'hBF80_0000; st_b[2] = 32'h3F80_0000; st_e[2] = 32'd1;
        st_a[3] = 32'h3F80_0000; st_b[3] = 32'hBF80_0000; st_e[3] = 32'd0;
        i = 0; stall = 0; seen = 0; drop_seen = 0;
        for (int t = 0; t < 40 && !(i == 4 && sb.size() == 0); t++) begin
            @(negedge clk);
            if (bus.out_valid && !seen) begin
                seen  = 1;
                stall = 3;
            end
            bus.out_ready = (stall == 0);
            if (stall > 0) stall--;
            if (i < 4) begin
                bus.in_valid = 1'b1;
                bus.op       = FP_OP_FLT;
                bus.rs1      = st_a[i];
                bus.rs2      = st_b[i];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && !bus.in_ready && !drop_seen) begin
                drop_seen = 1;
                check("stream_accepted_at_drop", i, 32'd2);
            end
            if (bus.in_valid && bus.in_ready) begin
                e.r = st_e[i]; e.nv = 1'b0; e.name = $sformatf("stream%0d", i);
                sb.push_back(e);
                i++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream_in_ready_dropped", {31'd0, drop_seen}, 32'd1);
        check("stream_all_accepted", i, 32'd4);
        drain("drain_stream");

        // Fill the pipe under backpressure, then reset mid-stream.
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(FP_OP_FLT, 32'h3F80_0000, 32'h4000_0000, 32'd1, 1'b0, "rst_a");
        send(FP_OP_FLT, 32'h4000_0000, 32'h3F80_0000, 32'd0, 1'b0, "rst_b");
        idle();
        check("prefill_in_ready", {31'd0, bus.in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("midrst_result",    bus.result,             32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;

        // Unit is usable again after reset.
        send(FP_OP_FMAX, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, "post_rst_fmax");
        idle();
        drain("drain_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_cmp_unit.md
# fp_cmp_unit

Pipelined RV32F compare/min-max/classify unit in the FP execute path, downstream of operand classification. Accepts two single-precision operands and an op code over a valid/ready handshake. Instantiates the classifier on each operand and returns FEQ.S / FLT.S / FLE.S / FMIN.S / FMAX.S / FCLASS.S results plus the invalid-operation (NV) flag after a fixed two-stage latency. Result feeds the integer writeback mux (compares, FCLASS) or the FP register file (min/max).

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand bundle valid
- in_ready  out  1  unit can accept a bundle this cycle
- op  in  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, 101 FCLASS, 110/111 reserved
- rs1  in  32  operand A (IEEE-754 single)
- rs2  in  32  operand B (ignored for FCLASS)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  compare → 0/1 zero-extended; min/max → FP value; FCLASS → 10-bit mask zero-extended
- fflag_nv  out  1  invalid-operation flag, qualified by out_valid

## Operation
- Stage 1 (S1): registers op, rs1, rs2 and both operands' class bits (snan, qnan, inf, zero, subnormal, normal, sign).
- Stage 2 (S2): computes result and fflag_nv from S1 registers; both registered at S2.
- Ordering: +0 == −0 for FEQ/FLT/FLE. Otherwise lt = (signA & ~signB & ~(zeroA & zeroB)) | (~signA & ~signB & magA<magB) | (signA & signB & magA>magB), mag = bits[30:0] unsigned; eq = (A==B) | (zeroA & zeroB).
- FEQ: quiet. Either NaN → 0; NV = snanA | snanB.
- FLT/FLE: signaling. Either NaN → 0; NV = any NaN.
- FMIN/FMAX: both NaN → 0x7FC00000; one NaN → other operand; NV = snanA | snanB. Min/max treat −0 < +0.
- FCLASS: result[9:0] = class mask of rs1, [31:10] = 0; NV = 0.
- Reserved op: result 0, NV 0, still occupies pipeline slot.

## Timing
- Reset: S1/S2 valid = 0, out_valid = 0, result = 0, fflag_nv = 0, in_ready = 1.
- Transfer on valid & ready, both sides.
- s2_ready = ~s2_valid | out_ready; s1_ready = ~s1_valid | s2_ready; in_ready = s1_ready (combinational from out_ready).
- Latency: bundle accepted in cycle N → out_valid in cycle N+2 if no backpressure.
- Throughput: one bundle per cycle with out_ready held high.
- Backpressure: while out_valid & ~out_ready, result/fflag_nv stay stable; S1 holds if S2 is full; in_ready falls after both stages fill.
- Simultaneous accept into S1 and drain of S2 in the same cycle: legal, no bubble.
- rst mid-operation: in-flight bundles discarded immediately, regardless of clk.

## Configuration
- FP_CMP_FCLASS_EN defined: op 101 performs FCLASS as above.
- Not defined: op 101 is treated as reserved (result 0, NV 0); class-mask path removed. Classifier still used for NaN/zero detection.

## Structure
- Shared package fp_pkg: op encodings (FP_OP_FEQ…FP_OP_FCLASS), FP_CANON_NAN = 32'h7FC00000, class-mask bit positions.
- Sub-module: fp_class, two instances (rs1, rs2) feeding the S1 registers. Comparison logic stays inline.

## Test plan
- FEQ 0x80000000 vs 0x00000000, out_ready=1 → result 1, NV 0, out_valid exactly 2 cycles after accept.
- FLT 0x7FC00000 (qNaN) vs 0x3F800000 → result 0, NV 1; same with FEQ → result 0, NV 0.
- FMIN 0x7F800001 (sNaN) vs 0xC0000000 → result 0xC0000000, NV 1; FMAX of two qNaNs → 0x7FC00000, NV 0.
- FMIN 0x00000000 vs 0x80000000 → 0x80000000; FMAX → 0x00000000.
- FCLASS 0x00000001 → result 0x00000020; 0xFF800000 → 0x00000001; without FP_CMP_FCLASS_EN → 0.
- Stream 4 back-to-back FLT ops, hold out_ready=0 for 3 cycles after first out_valid → in_ready drops after 2 accepted, result stable, no loss or reorder; rst asserted mid-stream → out_valid 0 and in_ready 1 immediately.
